// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma character-side logic.
package enigma_pkg;

  localparam int NUM_LETTERS = 26;

  typedef logic [NUM_LETTERS-1:0] onehot_t;
  typedef logic [4:0]             letter_idx_t;

  localparam logic [7:0] CH_A   = 8'h41;
  localparam logic [7:0] CH_Z   = 8'h5A;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LZ  = 8'h7A;
  localparam logic [7:0] CH_ERR = 8'h3F;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4
  } port_state_t;

  function automatic logic is_upper(input logic [7:0] ch);
    return (ch >= CH_A) && (ch <= CH_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] ch);
    return (ch >= CH_LA) && (ch <= CH_LZ);
  endfunction

  // Case-folds a letter to 0..25; only meaningful when the input is a letter.
  function automatic letter_idx_t fold_index(input logic [7:0] ch);
    logic [7:0] off;
    if (is_upper(ch)) begin
      off = ch - CH_A;
    end else begin
      off = ch - CH_LA;
    end
    return off[4:0];
  endfunction

endpackage

// File: rtl/enigma_char_port_if.sv
// Keystroke stream, lamp stream and scrambler path of the character port.
interface enigma_char_port_if;
  import enigma_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       step;
  onehot_t    fwd_onehot;
  onehot_t    ret_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;

  // The character port itself.
  modport master (
    input  in_valid, in_char, ret_onehot, out_ready,
    output in_ready, step, fwd_onehot, out_valid, out_char
  );

  // Keyboard, scrambler and lampboard side.
  modport slave (
    output in_valid, in_char, ret_onehot, out_ready,
    input  in_ready, step, fwd_onehot, out_valid, out_char
  );

endinterface

// File: rtl/enigma_onehot_enc.sv
// One-hot to index encoder with a legality flag (zero or multiple bits set -> not ok).
module enigma_onehot_enc
  import enigma_pkg::*;
(
  input  onehot_t     onehot,
  output letter_idx_t idx,
  output logic        one_hot_ok
);

  letter_idx_t idx_s;
  logic        seen_s;
  logic        multi_s;

  // OR together the indices of set bits and note whether more than one is set.
  always_comb begin
    idx_s   = 5'd0;
    seen_s  = 1'b0;
    multi_s = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      multi_s = multi_s | (seen_s & onehot[i]);
      seen_s  = seen_s | onehot[i];
      idx_s   = idx_s | (onehot[i] ? 5'(i) : 5'd0);
    end
  end

  assign idx        = idx_s;
  assign one_hot_ok = seen_s & ~multi_s;

endmodule

// File: rtl/enigma_char_port.sv
// Character-side end of the Enigma path: keystroke in, rotor step, scrambler
// round trip, enciphered letter out, with a legality check on the return.
module enigma_char_port
  import enigma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter bit PASS_NONALPHA = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  enigma_char_port_if.master bus,
  input  logic               err_clr,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   enc_count
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

  port_state_t         state_r;
  logic [SETTLE_W-1:0] settle_cnt_r;
  logic                in_ready_r;
  logic                step_r;
  onehot_t             fwd_r;
  logic                out_valid_r;
  logic [7:0]          out_char_r;
  logic                err_r;
  logic [CNT_W-1:0]    enc_r;

  onehot_t     ret_gated_s;
  letter_idx_t ret_idx_s;
  logic        ret_ok_s;
  logic        legal_s;
  logic        in_is_letter_s;

  // Only look at the lamp return while capturing so stray X elsewhere stays contained.
  always_comb begin
    if (state_r == CAPTURE) begin
      ret_gated_s = bus.ret_onehot;
    end else begin
      ret_gated_s = {NUM_LETTERS{1'b0}};
    end
    in_is_letter_s = is_upper(bus.in_char) | is_lower(bus.in_char);
    legal_s        = ret_ok_s & (ret_gated_s != fwd_r);
  end

  enigma_onehot_enc u_ret_enc (
    .onehot     (ret_gated_s),
    .idx        (ret_idx_s),
    .one_hot_ok (ret_ok_s)
  );

  // Main sequencer: accept, step, settle, capture, present result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= {SETTLE_W{1'b0}};
      in_ready_r   <= 1'b0;
      step_r       <= 1'b0;
      fwd_r        <= {NUM_LETTERS{1'b0}};
      out_valid_r  <= 1'b0;
      out_char_r   <= 8'h00;
    end else begin
      step_r <= 1'b0;
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            if (in_is_letter_s) begin
              state_r    <= STEP;
              step_r     <= 1'b1;
              fwd_r      <= {{(NUM_LETTERS-1){1'b0}}, 1'b1} << fold_index(bus.in_char);
              in_ready_r <= 1'b0;
            end else if (PASS_NONALPHA) begin
              state_r     <= OUTPUT;
              out_char_r  <= bus.in_char;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        STEP: begin
          settle_cnt_r <= {SETTLE_W{1'b0}};
          state_r      <= (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= CAPTURE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 1'b1;
          end
        end
        CAPTURE: begin
          out_char_r  <= legal_s ? (CH_A + {3'b000, ret_idx_s}) : CH_ERR;
          out_valid_r <= 1'b1;
          fwd_r       <= {NUM_LETTERS{1'b0}};
          state_r     <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          fwd_r       <= {NUM_LETTERS{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: a bad return in the capture cycle beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == CAPTURE) && !legal_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end
  end

  // Count every capture, legal or not; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_r <= {CNT_W{1'b0}};
    end else if (state_r == CAPTURE) begin
      enc_r <= enc_r + CNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.step       = step_r;
  assign bus.fwd_onehot = fwd_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_char   = out_char_r;
  assign err_sticky     = err_r;
  assign enc_count      = enc_r;

endmodule

// File: tb/tb_enigma_char_port.sv
// Bench for enigma_char_port. Scrambler model: identity rotors with the
// A<->Z, B<->Y ... reflector. A second instance runs with no settle wait,
// non-letters dropped and a 4-bit counter so wrap-around is reachable.
module tb_enigma_char_port;
  import enigma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       err_clr, err_clr2;
  logic       err_sticky, err_sticky2;
  logic [15:0] enc_count;
  logic [3:0]  enc_count2;

  enigma_char_port_if bus ();
  enigma_char_port_if bus2 ();

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0: reflector, 1: two bits set, 2: echo of fwd_onehot
  int exp_enc  = 0;
  int exp_enc2 = 0;
  logic [7:0] q[$];
  logic [7:0] q2[$];

  function automatic onehot_t reflect(input onehot_t f);
    onehot_t r;
    for (int i = 0; i < 26; i++) r[25-i] = f[i];
    return r;
  endfunction

  assign bus.ret_onehot = (mode == 1) ? 26'h3 :
                          (mode == 2) ? bus.fwd_onehot :
                          (bus.fwd_onehot == 26'h0) ? {26{1'bx}} : reflect(bus.fwd_onehot);
  assign bus2.ret_onehot = (bus2.fwd_onehot == 26'h0) ? {26{1'bx}} : reflect(bus2.fwd_onehot);

  enigma_char_port #(.SETTLE_CYCLES(2), .PASS_NONALPHA(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr),
    .err_sticky(err_sticky), .enc_count(enc_count)
  );

  enigma_char_port #(.SETTLE_CYCLES(0), .PASS_NONALPHA(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .err_clr(err_clr2),
    .err_sticky(err_sticky2), .enc_count(enc_count2)
  );

  // Scoreboard for the main instance: pop on every output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_main: got out_char %h with nothing expected", bus.out_char);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        if (bus.out_char !== e) begin
          bad++;
          $display("FAIL sb_main: got %h want %h", bus.out_char, e);
        end
      end
    end
  end

  // Scoreboard for the second instance.
  always @(negedge clk) begin
    if (!rst && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL sb_drop: got out_char %h with nothing expected", bus2.out_char);
      end else begin
        logic [7:0] e;
        e = q2.pop_front();
        if (bus2.out_char !== e) begin
          bad++;
          $display("FAIL sb_drop: got %h want %h", bus2.out_char, e);
        end
      end
    end
  end

  // Stimulus only: caller is at posedge+1 with the main port idle.
  task automatic drive_char(input logic [7:0] ch);
    bus.in_valid = 1'b1;
    bus.in_char  = ch;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rst_step: got %b want 0", bus.step); end
    total++; if (bus.fwd_onehot !== 26'h0) begin bad++; $display("FAIL rst_fwd: got %h want 0", bus.fwd_onehot); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_char !== 8'h00) begin bad++; $display("FAIL rst_out_char: got %h want 00", bus.out_char); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_sticky); end
    total++; if (enc_count !== 16'h0) begin bad++; $display("FAIL rst_enc: got %h want 0", enc_count); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_early: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus2.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready2: got %b want 1", bus2.in_ready); end
  endtask

  task automatic test_letter_a();
    @(posedge clk); #1;
    q.push_back(8'h5A);
    drive_char(8'h41);
    exp_enc++;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++; if (bus.step !== (c == 1)) begin bad++; $display("FAIL a_step c=%0d: got %b want %b", c, bus.step, (c == 1)); end
      total++; if (bus.fwd_onehot !== ((c <= 4) ? 26'h1 : 26'h0)) begin bad++; $display("FAIL a_fwd c=%0d: got %h", c, bus.fwd_onehot); end
      total++; if (bus.out_valid !== (c == 5)) begin bad++; $display("FAIL a_out_valid c=%0d: got %b want %b", c, bus.out_valid, (c == 5)); end
      total++; if (bus.in_ready !== (c == 6)) begin bad++; $display("FAIL a_in_ready c=%0d: got %b want %b", c, bus.in_ready, (c == 6)); end
    end
    total++; if (enc_count !== 16'(exp_enc)) begin bad++; $display("FAIL a_enc: got %0d want %0d", enc_count, exp_enc); end
  endtask

  task automatic test_backpressure_b();
    int n;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    q.push_back(8'h59);
    drive_char(8'h62);
    exp_enc++;
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b_timeout: out_valid got %b want 1", bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b_hold_valid i=%0d: got %b want 1", i, bus.out_valid); end
      total++; if (bus.out_char !== 8'h59) begin bad++; $display("FAIL b_hold_char i=%0d: got %h want 59", i, bus.out_char); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b_hold_in_ready i=%0d: got %b want 0", i, bus.in_ready); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b_hs_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b_after_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b_after_valid: got %b want 0", bus.out_valid); end
    total++; if (enc_count !== 16'(exp_enc)) begin bad++; $display("FAIL b_enc: got %0d want %0d", enc_count, exp_enc); end
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    q.push_back(8'h20);
    drive_char(8'h20);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_char !== 8'h20) begin bad++; $display("FAIL pass_char: got %h want 20", bus.out_char); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL pass_step: got %b want 0", bus.step); end
    total++; if (bus.fwd_onehot !== 26'h0) begin bad++; $display("FAIL pass_fwd: got %h want 0", bus.fwd_onehot); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready: got %b want 1", bus.in_ready); end
    total++; if (enc_count !== 16'(exp_enc)) begin bad++; $display("FAIL pass_enc: got %0d want %0d", enc_count, exp_enc); end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    bus2.in_valid = 1'b1;
    bus2.in_char  = 8'h20;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++; if (bus2.out_valid !== 1'b0) begin bad++; $display("FAIL drop_valid c=%0d: got %b want 0", c, bus2.out_valid); end
      total++; if (bus2.in_ready !== 1'b1) begin bad++; $display("FAIL drop_in_ready c=%0d: got %b want 1", c, bus2.in_ready); end
      total++; if (bus2.step !== 1'b0) begin bad++; $display("FAIL drop_step c=%0d: got %b want 0", c, bus2.step); end
    end
    @(posedge clk); #1;
    q2.push_back(8'h58);
    bus2.in_valid = 1'b1;
    bus2.in_char  = 8'h43;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    exp_enc2++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++; if (bus2.step !== (c == 1)) begin bad++; $display("FAIL z_step c=%0d: got %b", c, bus2.step); end
      total++; if (bus2.fwd_onehot !== ((c <= 2) ? 26'h4 : 26'h0)) begin bad++; $display("FAIL z_fwd c=%0d: got %h", c, bus2.fwd_onehot); end
      total++; if (bus2.out_valid !== (c == 3)) begin bad++; $display("FAIL z_valid c=%0d: got %b", c, bus2.out_valid); end
      total++; if (bus2.in_ready !== (c == 4)) begin bad++; $display("FAIL z_in_ready c=%0d: got %b", c, bus2.in_ready); end
    end
    total++; if (enc_count2 !== 4'(exp_enc2)) begin bad++; $display("FAIL z_enc: got %0d want %0d", enc_count2, exp_enc2); end
  endtask

  task automatic test_errors();
    // Two-bit return on 'D'
    @(posedge clk); #1;
    mode = 1;
    q.push_back(8'h3F);
    drive_char(8'h44);
    exp_enc++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 3) begin
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL e1_early: got %b want 0", err_sticky); end
      end
    end
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL e1_err: got %b want 1", err_sticky); end
    total++; if (bus.out_char !== 8'h3F) begin bad++; $display("FAIL e1_char: got %h want 3f", bus.out_char); end
    @(negedge clk);
    mode = 0;
    // clear
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL e_clr: got %b want 0", err_sticky); end
    // Return equals the forward letter on 'E'
    @(posedge clk); #1;
    mode = 2;
    q.push_back(8'h3F);
    drive_char(8'h45);
    exp_enc++;
    repeat (5) @(negedge clk);
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL e2_err: got %b want 1", err_sticky); end
    total++; if (bus.out_char !== 8'h3F) begin bad++; $display("FAIL e2_char: got %h want 3f", bus.out_char); end
    @(negedge clk);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL e_clr2: got %b want 0", err_sticky); end
    // Clear held through the capture cycle of another bad return on 'F'
    @(posedge clk); #1;
    q.push_back(8'h3F);
    drive_char(8'h46);
    exp_enc++;
    err_clr = 1'b1;
    repeat (4) @(posedge clk);
    #1; err_clr = 1'b0;
    @(negedge clk);
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL e3_coincident: got %b want 1", err_sticky); end
    total++; if (enc_count !== 16'(exp_enc)) begin bad++; $display("FAIL e_enc: got %0d want %0d", enc_count, exp_enc); end
    @(negedge clk);
    mode = 0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive_char(8'h47);
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.fwd_onehot !== 26'h40) begin bad++; $display("FAIL rm_fwd_pre: got %h want 40", bus.fwd_onehot); end
    rst = 1'b1;
    #1;
    total++; if (bus.fwd_onehot !== 26'h0) begin bad++; $display("FAIL rm_fwd: got %h want 0", bus.fwd_onehot); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rm_step: got %b want 0", bus.step); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rm_in_ready: got %b want 0", bus.in_ready); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rm_err: got %b want 0", err_sticky); end
    total++; if (enc_count !== 16'h0) begin bad++; $display("FAIL rm_enc: got %0d want 0", enc_count); end
    exp_enc  = 0;
    exp_enc2 = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    q.push_back(8'h58);
    drive_char(8'h43);
    exp_enc++;
    repeat (5) @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_c_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_char !== 8'h58) begin bad++; $display("FAIL rm_c_char: got %h want 58", bus.out_char); end
    @(negedge clk);
    total++; if (enc_count !== 16'(exp_enc)) begin bad++; $display("FAIL rm_c_enc: got %0d want %0d", enc_count, exp_enc); end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      q2.push_back(8'(8'h5A - k));
      bus2.in_valid = 1'b1;
      bus2.in_char  = 8'(8'h41 + k);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_enc2++;
      if (k == 14) begin
        @(negedge clk);
        total++; if (enc_count2 !== 4'hF) begin bad++; $display("FAIL wrap_full: got %h want f", enc_count2); end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    total++; if (enc_count2 !== 4'(exp_enc2 % 16)) begin bad++; $display("FAIL wrap_zero: got %h want %h", enc_count2, 4'(exp_enc2 % 16)); end
  endtask

  initial begin
    rst = 1'b0;
    err_clr = 1'b0;
    err_clr2 = 1'b0;
    bus.in_valid = 1'b0;  bus.in_char = 8'h00;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_char = 8'h00; bus2.out_ready = 1'b1;
    #1 rst = 1'b1;
    test_reset();
    test_letter_a();
    test_backpressure_b();
    test_passthrough();
    test_drop();
    test_errors();
    test_reset_mid();
    test_wrap();
    repeat (3) @(negedge clk);
    total++; if (q.size() != 0) begin bad++; $display("FAIL sb_main_left: got %0d pending want 0", q.size()); end
    total++; if (q2.size() != 0) begin bad++; $display("FAIL sb_drop_left: got %0d pending want 0", q2.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
